dps_irq_ctrl: RTL
=================

Name: dps_irq_ctrl

Overview:
Parametrised interrupt controller for the DPS block; generalised from the two-source fixed-priority IRQ unit to P_CH_NUM sources. Each channel has a config-table entry (valid, mask, edge/level mode, 2-bit priority level). Edge-mode channels have a pending latch. A priority arbiter selects one channel and presents it to the core with a valid/ack handshake, pulsing the acknowledge back to the winning source.

Parameters:
P_CH_NUM, 4, number of IRQ source channels (2..16)
P_CH_WIDTH, 2, width of channel index; must equal clog2(P_CH_NUM)

Ports:
iCLOCK  in  1  clock
inRESET  in  1  reset, asynchronous, active-low
iDPS_IRQ_CONFIG_TABLE_REQ  in  1  config-table write strobe
iDPS_IRQ_CONFIG_TABLE_ENTRY  in  P_CH_WIDTH  channel index to write
iDPS_IRQ_CONFIG_TABLE_FLAG_MASK  in  1  1 = channel permitted when entry valid
iDPS_IRQ_CONFIG_TABLE_FLAG_VALID  in  1  entry valid
iDPS_IRQ_CONFIG_TABLE_FLAG_EDGE  in  1  1 = rising-edge mode, 0 = level mode
iDPS_IRQ_CONFIG_TABLE_FLAG_LEVEL  in  2  priority level; 3 = highest
iIRQ_REQ  in  P_CH_NUM  per-source request
oIRQ_SRC_ACK  out  P_CH_NUM  per-source acknowledge, one-hot one-cycle pulse
oIRQ_PENDING  out  P_CH_NUM  edge-pending latches (status)
oIRQ_VALID  out  1  interrupt presented to core
oIRQ_NUM  out  P_CH_WIDTH  presented channel index
oIRQ_LEVEL  out  2  presented channel priority
iIRQ_ACK  in  1  core accepts the presented interrupt

Behaviour:
- Reset values: all config fields 0 (valid = 0, mask = 0, edge = 0, level = 0). Pending = 0, req_d = 0, state IDLE. oIRQ_VALID = 0, oIRQ_NUM = 0, oIRQ_LEVEL = 0, oIRQ_SRC_ACK = 0, oIRQ_PENDING = 0.
- Config write: on a clock with REQ = 1, the entry's fields are registered. An entry index >= P_CH_NUM is ignored. The arbiter sees the new config the cycle after the write. An in-flight presented IRQ is unaffected by config writes.
- Enable: a channel is enabled when (!valid) || (valid && mask). An unconfigured channel is open by default, matching the previous generation.
- Edge detect: req_d is iIRQ_REQ registered each cycle. rise[i] = iIRQ_REQ[i] && !req_d[i].
  - Edge-mode channel: a rise sets pending[i] regardless of enable.
  - pending[i] clears on the cycle channel i is dispatched.
  - If a rise and a dispatch hit the same channel in the same cycle, set wins.
  - Pending is retained while the channel is disabled and is dispatched once it is re-enabled.
  - Level-mode channels never set pending.
- Candidate: cand[i] = enabled[i] && (edge[i] ? pending[i] : iIRQ_REQ[i]).
- Arbiter (combinational): selects the candidate with the highest level. Ties go to the lowest channel index.
- State machine, 2 states:
  - IDLE: if any cand, register winner index and level into oIRQ_NUM/oIRQ_LEVEL, go to ACK_WAIT. In that same cycle, oIRQ_SRC_ACK[winner] = 1 (combinational, only in IDLE), and the winner's pending clears if it is edge-mode.
  - ACK_WAIT: oIRQ_VALID = 1; oIRQ_NUM/oIRQ_LEVEL held stable; arbiter ignored; no source acks. On iIRQ_ACK = 1, go to IDLE next clock.
  - iIRQ_ACK while in IDLE is ignored.
- Latency: request asserted in cycle N (level mode, enabled) gives SRC_ACK in cycle N and oIRQ_VALID from N+1. Edge mode adds 1 cycle (pending latch).
- Back-to-back: after ACK, at least one IDLE cycle before the next dispatch. Minimum dispatch period is 2 cycles plus core ack latency.
- Level-mode source must drop its request on SRC_ACK. If it is still high in the next IDLE cycle, it is dispatched again (by design).
- Asynchronous reset mid-handshake: everything returns to reset values immediately, including oIRQ_VALID = 0. Pending interrupts are lost.

Test Plan:
- Reset defaults: after reset, pulse iIRQ_REQ[2] high 1 cycle (level mode, unconfigured) -> SRC_ACK = 4'b0100 that cycle; next cycle oIRQ_VALID = 1, oIRQ_NUM = 2, oIRQ_LEVEL = 0. iIRQ_ACK -> VALID = 0 next cycle.
- Priority: config ch1 level 1, ch3 level 3 (valid = 1, mask = 1). Assert REQ[1] and REQ[3] together -> NUM = 3 first. After ack and ch3 dropped, NUM = 1. Equal levels on ch0/ch2 -> NUM = 0 first.
- Masking: config ch2 valid = 1, mask = 0, edge = 1. Rising edge on REQ[2] -> PENDING = 4'b0100, VALID stays 0. Rewrite mask = 1 -> dispatch of NUM = 2 on the next IDLE cycle, pending cleared.
- Edge during ACK_WAIT: ch0 edge mode. Dispatch ch0, then a second rise on REQ[0] while in ACK_WAIT -> pending[0] = 1. After ack, ch0 is redispatched; 2 SRC_ACK pulses total.
- Config index out of range (P_CH_NUM = 3, ENTRY = 3) -> no state change.
- Async reset asserted while in ACK_WAIT -> VALID, NUM, PENDING = 0 immediately; no SRC_ACK after release until a new request arrives.

Source files
------------

// File: rtl/dps_irq_ctrl.sv
// Parametrised interrupt controller: per-channel config table, edge pending latches,
// fixed-priority arbiter and a valid/ack handshake toward the core.
module dps_irq_ctrl #(
    parameter int P_CH_NUM   = 4,
    parameter int P_CH_WIDTH = 2
) (
    input  logic                  iCLOCK,
    input  logic                  inRESET,
    input  logic                  iDPS_IRQ_CONFIG_TABLE_REQ,
    input  logic [P_CH_WIDTH-1:0] iDPS_IRQ_CONFIG_TABLE_ENTRY,
    input  logic                  iDPS_IRQ_CONFIG_TABLE_FLAG_MASK,
    input  logic                  iDPS_IRQ_CONFIG_TABLE_FLAG_VALID,
    input  logic                  iDPS_IRQ_CONFIG_TABLE_FLAG_EDGE,
    input  logic [1:0]            iDPS_IRQ_CONFIG_TABLE_FLAG_LEVEL,
    input  logic [P_CH_NUM-1:0]   iIRQ_REQ,
    output logic [P_CH_NUM-1:0]   oIRQ_SRC_ACK,
    output logic [P_CH_NUM-1:0]   oIRQ_PENDING,
    output logic                  oIRQ_VALID,
    output logic [P_CH_WIDTH-1:0] oIRQ_NUM,
    output logic [1:0]            oIRQ_LEVEL,
    input  logic                  iIRQ_ACK
);

    typedef enum logic {
        L_IDLE     = 1'b0,
        L_ACK_WAIT = 1'b1
    } state_t;

    state_t                     r_state;
    logic [P_CH_NUM-1:0]        r_cfg_valid;
    logic [P_CH_NUM-1:0]        r_cfg_mask;
    logic [P_CH_NUM-1:0]        r_cfg_edge;
    logic [P_CH_NUM-1:0][1:0]   r_cfg_level;
    logic [P_CH_NUM-1:0]        r_req_d;
    logic [P_CH_NUM-1:0]        r_pending;
    logic                       r_valid;
    logic [P_CH_WIDTH-1:0]      r_num;
    logic [1:0]                 r_level;

    logic [P_CH_NUM-1:0]        w_enable;
    logic [P_CH_NUM-1:0]        w_rise;
    logic [P_CH_NUM-1:0]        w_cand;
    logic [P_CH_NUM-1:0]        w_win_onehot;
    logic [P_CH_NUM-1:0]        w_pend_set;
    logic [P_CH_NUM-1:0]        w_pend_clr;
    logic                       w_any;
    logic                       w_dispatch;
    logic [P_CH_WIDTH-1:0]      w_win_idx;
    logic [1:0]                 w_win_level;

    // Unconfigured channels stay open so legacy sources work without setup.
    assign w_enable = ~r_cfg_valid | r_cfg_mask;
    assign w_rise   = iIRQ_REQ & ~r_req_d;
    assign w_cand   = w_enable & ((r_cfg_edge & r_pending) | (~r_cfg_edge & iIRQ_REQ));

    // Strictly-greater update while scanning upward keeps ties on the lowest index.
    always_comb begin
        w_any       = 1'b0;
        w_win_idx   = '0;
        w_win_level = 2'd0;
        for (int i = 0; i < P_CH_NUM; i++) begin
            if (w_cand[i] && (!w_any || (r_cfg_level[i] > w_win_level))) begin
                w_any       = 1'b1;
                w_win_idx   = P_CH_WIDTH'(i);
                w_win_level = r_cfg_level[i];
            end
        end
    end

    assign w_win_onehot = P_CH_NUM'(1) << w_win_idx;
    assign w_dispatch   = inRESET && (r_state == L_IDLE) && w_any;
    assign oIRQ_SRC_ACK = w_dispatch ? w_win_onehot : '0;

    assign w_pend_set   = r_cfg_edge & w_rise;
    assign w_pend_clr   = w_dispatch ? (w_win_onehot & r_cfg_edge) : '0;

    // An entry index with no matching channel simply matches nothing.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_cfg_valid <= '0;
            r_cfg_mask  <= '0;
            r_cfg_edge  <= '0;
            r_cfg_level <= '0;
        end else if (iDPS_IRQ_CONFIG_TABLE_REQ) begin
            for (int i = 0; i < P_CH_NUM; i++) begin
                if (iDPS_IRQ_CONFIG_TABLE_ENTRY == P_CH_WIDTH'(i)) begin
                    r_cfg_valid[i] <= iDPS_IRQ_CONFIG_TABLE_FLAG_VALID;
                    r_cfg_mask[i]  <= iDPS_IRQ_CONFIG_TABLE_FLAG_MASK;
                    r_cfg_edge[i]  <= iDPS_IRQ_CONFIG_TABLE_FLAG_EDGE;
                    r_cfg_level[i] <= iDPS_IRQ_CONFIG_TABLE_FLAG_LEVEL;
                end
            end
        end
    end

    // A new rise on the channel being dispatched re-arms it.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_req_d   <= '0;
            r_pending <= '0;
        end else begin
            r_req_d   <= iIRQ_REQ;
            r_pending <= (r_pending & ~w_pend_clr) | w_pend_set;
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_state <= L_IDLE;
            r_valid <= 1'b0;
            r_num   <= '0;
            r_level <= 2'd0;
        end else begin
            case (r_state)
                L_IDLE: begin
                    if (w_any) begin
                        r_state <= L_ACK_WAIT;
                        r_valid <= 1'b1;
                        r_num   <= w_win_idx;
                        r_level <= w_win_level;
                    end
                end
                L_ACK_WAIT: begin
                    if (iIRQ_ACK) begin
                        r_state <= L_IDLE;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= L_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign oIRQ_PENDING = r_pending;
    assign oIRQ_VALID   = r_valid;
    assign oIRQ_NUM     = r_num;
    assign oIRQ_LEVEL   = r_level;

endmodule
